// File: rtl/fpu_ss_pkg.sv
// Shared types and defaults for the FPU subsystem scoreboard.
package fpu_ss_pkg;

  localparam int unsigned X_ID_WIDTH          = 4;
  localparam int unsigned NUM_FP_REGS_DEFAULT = 32;
  localparam int unsigned FP_ADDR_WIDTH       = 5;

  typedef struct packed {
    logic                     valid;
    logic [FP_ADDR_WIDTH-1:0] rd;
    logic                     rd_is_fp;
  } sb_entry_t;

  typedef enum logic {
    SbRun   = 1'b0,
    SbDrain = 1'b1
  } sb_state_e;

endpackage

// File: rtl/fpu_ss_sb_hazard.sv
// Combinational hazard detection for the scoreboard; per-cause flags are exported
// so that stall statistics can reuse them.
module fpu_ss_sb_hazard
  import fpu_ss_pkg::*;
#(
  parameter int unsigned NUM_FP_REGS     = NUM_FP_REGS_DEFAULT,
  parameter int unsigned ID_WIDTH        = X_ID_WIDTH,
  parameter int unsigned MAX_OUTSTANDING = 4,
  localparam int unsigned CNT_W          = $clog2(MAX_OUTSTANDING + 1)
) (
  input  logic [NUM_FP_REGS-1:0]     busy_q,
  input  logic [(2**ID_WIDTH)-1:0]   valid_q,
  input  logic [CNT_W-1:0]           cnt_q,
  input  logic [ID_WIDTH-1:0]        iss_id,
  input  logic [3*FP_ADDR_WIDTH-1:0] iss_rs_addr,
  input  logic [2:0]                 iss_rs_is_fp,
  input  logic [FP_ADDR_WIDTH-1:0]   iss_rd_addr,
  input  logic                       iss_rd_is_fp,
  output logic                       hazard,
  output logic                       raw,
  output logic                       waw,
  output logic                       id_reuse,
  output logic                       full
);

  always_comb begin
    raw = 1'b0;
    for (int unsigned i = 0; i < 3; i++) begin
      raw = raw | (iss_rs_is_fp[i] & busy_q[iss_rs_addr[FP_ADDR_WIDTH*i +: FP_ADDR_WIDTH]]);
    end
  end

  assign waw      = iss_rd_is_fp & busy_q[iss_rd_addr];
  assign id_reuse = valid_q[iss_id];
  assign full     = (cnt_q == CNT_W'(MAX_OUTSTANDING));
  assign hazard   = raw | waw | id_reuse | full;

endmodule

// File: rtl/fpu_ss_scoreboard.sv
// Issue scoreboard between FPU offload/decode and fpnew/LSU dispatch.
// Optional stall counters are built when FPU_SS_SCOREBOARD_PERF_EN is defined.
module fpu_ss_scoreboard
  import fpu_ss_pkg::*;
#(
  parameter int unsigned NUM_FP_REGS     = NUM_FP_REGS_DEFAULT,
  parameter int unsigned ID_WIDTH        = X_ID_WIDTH,
  parameter int unsigned MAX_OUTSTANDING = 4,
  localparam int unsigned CNT_W          = $clog2(MAX_OUTSTANDING + 1)
) (
  input  logic                       clk_i,
  input  logic                       rst_ni,
  input  logic                       iss_valid_i,
  output logic                       iss_ready_o,
  input  logic [ID_WIDTH-1:0]        iss_id_i,
  input  logic [3*FP_ADDR_WIDTH-1:0] iss_rs_addr_i,
  input  logic [2:0]                 iss_rs_is_fp_i,
  input  logic [FP_ADDR_WIDTH-1:0]   iss_rd_addr_i,
  input  logic                       iss_rd_is_fp_i,
  output logic                       disp_valid_o,
  input  logic                       disp_ready_i,
  input  logic                       wb_valid_i,
  input  logic [ID_WIDTH-1:0]        wb_id_i,
  input  logic                       flush_i,
  output logic [NUM_FP_REGS-1:0]     busy_o,
  output logic [CNT_W-1:0]           outstanding_o,
  output logic                       idle_o,
`ifdef FPU_SS_SCOREBOARD_PERF_EN
  output logic [31:0]                stall_raw_cnt_o,
  output logic [31:0]                stall_full_cnt_o,
`endif
  output logic                       wb_err_o
);

  localparam int unsigned NUM_IDS = 2**ID_WIDTH;

  sb_entry_t                table_q [NUM_IDS];
  sb_entry_t                wb_entry;
  logic [NUM_IDS-1:0]       valid_vec;
  logic [NUM_FP_REGS-1:0]   busy_q, busy_d;
  logic [CNT_W-1:0]         cnt_q, cnt_d;
  sb_state_e                fsm_q;
  logic                     wb_err_q;
  logic                     hazard, haz_raw, haz_waw, haz_id, haz_full;
  logic                     can_issue, fire, retire;

  always_comb begin
    for (int unsigned i = 0; i < NUM_IDS; i++) begin
      valid_vec[i] = table_q[i].valid;
    end
  end

  fpu_ss_sb_hazard #(
    .NUM_FP_REGS     (NUM_FP_REGS),
    .ID_WIDTH        (ID_WIDTH),
    .MAX_OUTSTANDING (MAX_OUTSTANDING)
  ) u_hazard (
    .busy_q       (busy_q),
    .valid_q      (valid_vec),
    .cnt_q        (cnt_q),
    .iss_id       (iss_id_i),
    .iss_rs_addr  (iss_rs_addr_i),
    .iss_rs_is_fp (iss_rs_is_fp_i),
    .iss_rd_addr  (iss_rd_addr_i),
    .iss_rd_is_fp (iss_rd_is_fp_i),
    .hazard       (hazard),
    .raw          (haz_raw),
    .waw          (haz_waw),
    .id_reuse     (haz_id),
    .full         (haz_full)
  );

  // Hazards use registered state only, so a retirement frees a register one cycle later.
  assign can_issue    = ~hazard & (fsm_q == SbRun) & ~flush_i;
  assign disp_valid_o = iss_valid_i & can_issue;
  assign iss_ready_o  = disp_ready_i & can_issue;
  assign fire         = iss_valid_i & iss_ready_o;
  assign wb_entry     = table_q[wb_id_i];
  assign retire       = wb_valid_i & wb_entry.valid;

  // Set after clear so a new pending write wins over a retirement of the same register.
  always_comb begin
    busy_d = busy_q;
    if (retire && wb_entry.rd_is_fp) busy_d[wb_entry.rd] = 1'b0;
    if (fire && iss_rd_is_fp_i)      busy_d[iss_rd_addr_i] = 1'b1;
  end

  always_comb begin
    cnt_d = cnt_q;
    if (fire && !retire && cnt_q != CNT_W'(MAX_OUTSTANDING)) begin
      cnt_d = cnt_q + CNT_W'(1);
    end else if (!fire && retire && cnt_q != '0) begin
      cnt_d = cnt_q - CNT_W'(1);
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      for (int unsigned i = 0; i < NUM_IDS; i++) begin
        table_q[i] <= '0;
      end
      busy_q   <= '0;
      cnt_q    <= '0;
      fsm_q    <= SbRun;
      wb_err_q <= 1'b0;
    end else begin
      wb_err_q <= wb_valid_i & ~wb_entry.valid;
      if (retire) table_q[wb_id_i].valid <= 1'b0;
      if (fire) begin
        table_q[iss_id_i].valid    <= 1'b1;
        table_q[iss_id_i].rd       <= iss_rd_addr_i;
        table_q[iss_id_i].rd_is_fp <= iss_rd_is_fp_i;
      end
      busy_q <= busy_d;
      cnt_q  <= cnt_d;
      case (fsm_q)
        SbRun:   if (flush_i) fsm_q <= SbDrain;
        SbDrain: if (cnt_q == '0 && !flush_i) fsm_q <= SbRun;
      endcase
    end
  end

  assign busy_o        = busy_q;
  assign outstanding_o = cnt_q;
  assign idle_o        = (cnt_q == '0) & (fsm_q == SbRun);
  assign wb_err_o      = wb_err_q;

`ifdef FPU_SS_SCOREBOARD_PERF_EN
  logic [31:0] raw_cnt_q, full_cnt_q;

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      raw_cnt_q  <= '0;
      full_cnt_q <= '0;
    end else begin
      if (iss_valid_i && fsm_q == SbRun && haz_raw)  raw_cnt_q  <= raw_cnt_q + 32'd1;
      if (iss_valid_i && fsm_q == SbRun && haz_full) full_cnt_q <= full_cnt_q + 32'd1;
    end
  end

  assign stall_raw_cnt_o  = raw_cnt_q;
  assign stall_full_cnt_o = full_cnt_q;
`endif

endmodule

// File: tb/tb_fpu_ss_scoreboard.sv
// Self-checking bench for fpu_ss_scoreboard: directed scenarios plus random traffic
// compared against an in-flight-set reference model.
module tb_fpu_ss_scoreboard;

  localparam int unsigned MAXO = 4;

  logic        clk = 1'b0;
  logic        rst_ni = 1'b0;
  logic        iss_valid_i = 1'b0, iss_ready_o;
  logic [3:0]  iss_id_i = '0;
  logic [14:0] iss_rs_addr_i = '0;
  logic [2:0]  iss_rs_is_fp_i = '0;
  logic [4:0]  iss_rd_addr_i = '0;
  logic        iss_rd_is_fp_i = 1'b0;
  logic        disp_valid_o, disp_ready_i = 1'b0;
  logic        wb_valid_i = 1'b0;
  logic [3:0]  wb_id_i = '0;
  logic        flush_i = 1'b0;
  logic [31:0] busy_o;
  logic [2:0]  outstanding_o;
  logic        idle_o, wb_err_o;
`ifdef FPU_SS_SCOREBOARD_PERF_EN
  logic [31:0] stall_raw_cnt_o, stall_full_cnt_o;
`endif

  always #5 clk = ~clk;

  fpu_ss_scoreboard dut (
    .clk_i          (clk),
    .rst_ni         (rst_ni),
    .iss_valid_i    (iss_valid_i),
    .iss_ready_o    (iss_ready_o),
    .iss_id_i       (iss_id_i),
    .iss_rs_addr_i  (iss_rs_addr_i),
    .iss_rs_is_fp_i (iss_rs_is_fp_i),
    .iss_rd_addr_i  (iss_rd_addr_i),
    .iss_rd_is_fp_i (iss_rd_is_fp_i),
    .disp_valid_o   (disp_valid_o),
    .disp_ready_i   (disp_ready_i),
    .wb_valid_i     (wb_valid_i),
    .wb_id_i        (wb_id_i),
    .flush_i        (flush_i),
    .busy_o         (busy_o),
    .outstanding_o  (outstanding_o),
    .idle_o         (idle_o),
`ifdef FPU_SS_SCOREBOARD_PERF_EN
    .stall_raw_cnt_o  (stall_raw_cnt_o),
    .stall_full_cnt_o (stall_full_cnt_o),
`endif
    .wb_err_o       (wb_err_o)
  );

  int n_vec = 0;
  int n_err = 0;

  // Reference model: set of in-flight ops keyed by id, value {rd_is_fp, rd}.
  logic [5:0]  inflight [int];
  bit          draining = 1'b0;
  bit          exp_err = 1'b0;
  int unsigned exp_raw = 0, exp_full = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic bit reg_busy(input logic [4:0] r);
    foreach (inflight[k]) if (inflight[k][5] && inflight[k][4:0] == r) return 1'b1;
    return 1'b0;
  endfunction

  task automatic do_reset();
    rst_ni = 1'b0;
    iss_valid_i = 1'b0; wb_valid_i = 1'b0; flush_i = 1'b0; disp_ready_i = 1'b0;
    @(posedge clk);
    inflight.delete();
    draining = 1'b0; exp_err = 1'b0; exp_raw = 0; exp_full = 0;
    @(negedge clk);
    rst_ni = 1'b1;
  endtask

  // One cycle: drive at negedge, check against the model, advance the model at posedge.
  task automatic step(input logic v, input logic [3:0] id, input logic [14:0] rs,
                      input logic [2:0] rsfp, input logic [4:0] rd, input logic rdfp,
                      input logic drdy, input logic wv, input logic [3:0] wid,
                      input logic fl, output logic obs_rdy);
    bit          raw, full, stall, can, fire;
    int          n_before;
    logic [31:0] busy_exp;
    iss_valid_i = v; iss_id_i = id; iss_rs_addr_i = rs; iss_rs_is_fp_i = rsfp;
    iss_rd_addr_i = rd; iss_rd_is_fp_i = rdfp; disp_ready_i = drdy;
    wb_valid_i = wv; wb_id_i = wid; flush_i = fl;
    #1;
    raw = 1'b0;
    for (int i = 0; i < 3; i++) if (rsfp[i] && reg_busy(rs[5*i +: 5])) raw = 1'b1;
    full  = (inflight.num() == MAXO);
    stall = raw || (rdfp && reg_busy(rd)) || inflight.exists(int'(id)) || full;
    can   = !stall && !draining && !fl;
    busy_exp = '0;
    for (int r = 0; r < 32; r++) busy_exp[r] = reg_busy(5'(r));
    check("disp_valid", 32'(disp_valid_o), 32'(v && can));
    check("iss_ready", 32'(iss_ready_o), 32'(drdy && can));
    check("busy", busy_o, busy_exp);
    check("outstanding", 32'(outstanding_o), 32'(inflight.num()));
    check("idle", 32'(idle_o), 32'(inflight.num() == 0 && !draining));
    check("wb_err", 32'(wb_err_o), 32'(exp_err));
`ifdef FPU_SS_SCOREBOARD_PERF_EN
    check("stall_raw_cnt", stall_raw_cnt_o, exp_raw);
    check("stall_full_cnt", stall_full_cnt_o, exp_full);
`endif
    obs_rdy = iss_ready_o;
    fire = v && drdy && can;
    @(posedge clk);
    n_before = inflight.num();
    if (v && !draining && raw)  exp_raw++;
    if (v && !draining && full) exp_full++;
    exp_err = wv && !inflight.exists(int'(wid));
    if (wv && inflight.exists(int'(wid))) inflight.delete(int'(wid));
    if (fire) inflight[int'(id)] = {rdfp, rd};
    if (!draining && fl) draining = 1'b1;
    else if (draining && n_before == 0 && !fl) draining = 1'b0;
    @(negedge clk);
  endtask

  initial begin
    logic r;
    @(negedge clk);
    do_reset();

    // Reset state, then a single FP-destination issue.
    check("rst_idle", 32'(idle_o), 32'd1);
    check("rst_busy", busy_o, 32'd0);
    step(1'b1, 4'd1, 15'd0, 3'b000, 5'd5, 1'b1, 1'b1, 1'b0, 4'd0, 1'b0, r);
    check("t1_fire", 32'(r), 32'd1);
    check("t1_busy5", 32'(busy_o[5]), 32'd1);
    check("t1_outstanding", 32'(outstanding_o), 32'd1);
    check("t1_idle", 32'(idle_o), 32'd0);

    // RAW on rs2=f5, writeback in the same cycle does not bypass.
    step(1'b1, 4'd2, 15'd160, 3'b010, 5'd6, 1'b1, 1'b1, 1'b1, 4'd1, 1'b0, r);
    check("t2_raw_stall", 32'(r), 32'd0);
    check("t2_busy5_clr", 32'(busy_o[5]), 32'd0);
    step(1'b1, 4'd2, 15'd160, 3'b010, 5'd6, 1'b1, 1'b1, 1'b0, 4'd0, 1'b0, r);
    check("t2_fire_after", 32'(r), 32'd1);

    // Full table: retire and present in the same cycle still stalls.
    do_reset();
    for (int i = 0; i < 4; i++)
      step(1'b1, 4'(i), 15'd0, 3'b000, 5'(i + 1), 1'b1, 1'b1, 1'b0, 4'd0, 1'b0, r);
    step(1'b1, 4'd4, 15'd0, 3'b000, 5'd5, 1'b1, 1'b1, 1'b0, 4'd0, 1'b0, r);
    check("t3_full_stall", 32'(r), 32'd0);
    step(1'b1, 4'd4, 15'd0, 3'b000, 5'd5, 1'b1, 1'b1, 1'b1, 4'd0, 1'b0, r);
    check("t3_retire_same_cycle", 32'(r), 32'd0);
    step(1'b1, 4'd4, 15'd0, 3'b000, 5'd5, 1'b1, 1'b1, 1'b0, 4'd0, 1'b0, r);
    check("t3_fire_next", 32'(r), 32'd1);
    check("t3_outstanding", 32'(outstanding_o), 32'd4);

    // Flush with two in flight, drain, return to RUN one cycle after empty.
    do_reset();
    step(1'b1, 4'd0, 15'd0, 3'b000, 5'd1, 1'b1, 1'b1, 1'b0, 4'd0, 1'b0, r);
    step(1'b1, 4'd1, 15'd0, 3'b000, 5'd2, 1'b1, 1'b1, 1'b0, 4'd0, 1'b0, r);
    step(1'b1, 4'd5, 15'd0, 3'b000, 5'd7, 1'b1, 1'b1, 1'b0, 4'd0, 1'b1, r);
    check("t4_flush_cycle", 32'(r), 32'd0);
    step(1'b1, 4'd5, 15'd0, 3'b000, 5'd7, 1'b1, 1'b1, 1'b1, 4'd0, 1'b0, r);
    check("t4_drain_block", 32'(r), 32'd0);
    step(1'b1, 4'd5, 15'd0, 3'b000, 5'd7, 1'b1, 1'b1, 1'b1, 4'd1, 1'b0, r);
    check("t4_drain_block2", 32'(r), 32'd0);
    step(1'b1, 4'd5, 15'd0, 3'b000, 5'd7, 1'b1, 1'b1, 1'b0, 4'd0, 1'b0, r);
    check("t4_drain_empty", 32'(r), 32'd0);
    check("t4_idle_back", 32'(idle_o), 32'd1);
    step(1'b1, 4'd5, 15'd0, 3'b000, 5'd7, 1'b1, 1'b1, 1'b0, 4'd0, 1'b0, r);
    check("t4_fire_run", 32'(r), 32'd1);

    // Spurious writeback.
    do_reset();
    step(1'b0, 4'd0, 15'd0, 3'b000, 5'd0, 1'b0, 1'b0, 1'b1, 4'd7, 1'b0, r);
    check("t5_wb_err", 32'(wb_err_o), 32'd1);
    check("t5_outstanding", 32'(outstanding_o), 32'd0);
    step(1'b0, 4'd0, 15'd0, 3'b000, 5'd0, 1'b0, 1'b0, 1'b0, 4'd0, 1'b0, r);
    check("t5_wb_err_pulse", 32'(wb_err_o), 32'd0);

    // Flush while empty: exactly one DRAIN cycle.
    step(1'b0, 4'd0, 15'd0, 3'b000, 5'd0, 1'b0, 1'b0, 1'b0, 4'd0, 1'b1, r);
    check("t6_drain_one", 32'(idle_o), 32'd0);
    step(1'b0, 4'd0, 15'd0, 3'b000, 5'd0, 1'b0, 1'b0, 1'b0, 4'd0, 1'b0, r);
    check("t6_run_again", 32'(idle_o), 32'd1);

    // Reset mid-operation discards the table.
    step(1'b1, 4'd3, 15'd0, 3'b000, 5'd9, 1'b1, 1'b1, 1'b0, 4'd0, 1'b0, r);
    do_reset();
    step(1'b0, 4'd0, 15'd0, 3'b000, 5'd0, 1'b0, 1'b0, 1'b1, 4'd3, 1'b0, r);
    check("t7_wb_after_reset", 32'(wb_err_o), 32'd1);

    // Random traffic against the model.
    for (int n = 0; n < 3000; n++) begin
      if ($urandom_range(0, 499) == 0) do_reset();
      step(1'($urandom_range(0, 3) != 0), 4'($urandom_range(0, 15)),
           {5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)), 5'($urandom_range(0, 7))},
           3'($urandom), 5'($urandom_range(0, 7)), 1'($urandom),
           1'($urandom_range(0, 4) != 0), 1'($urandom), 4'($urandom_range(0, 15)),
           1'($urandom_range(0, 39) == 0), r);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
